// File: rtl/imu_pkt_pkg.sv
// Shared constants, state encoding and byte-extraction helper for the
// IMU sample packer.
package imu_pkt_pkg;

    localparam int          PKT_LEN   = 24;
    localparam logic [4:0]  IDX_SEQ   = 5'd2;
    localparam logic [4:0]  IDX_DATA0 = 5'd3;
    localparam logic [4:0]  IDX_CSUM  = 5'(PKT_LEN - 1);

    localparam logic [7:0]  SYNC0_DEF = 8'hA5;
    localparam logic [7:0]  SYNC1_DEF = 8'h5A;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Returns data byte (idx - IDX_DATA0) of the snapshot. The snapshot holds
    // ACCEL_X in its top 16 bits down to HM_Z in its bottom 16 bits, so byte k
    // (high byte first) sits at bits [159-8k -: 8].
    function automatic logic [7:0] snap_byte(input logic [159:0] snap,
                                             input logic [4:0]   idx);
        logic [4:0]   k;
        logic [159:0] sh;
        k  = idx - IDX_DATA0;
        sh = snap << {k, 3'b000};
        return sh[159:152];
    endfunction

endpackage

// File: rtl/imu_sample_packer.sv
// Snapshots the ten 16-bit IMU words on SAMPLE_STB and streams them as a
// 24-byte framed packet (sync, sequence, data, checksum) over valid/ready.
module imu_sample_packer
    import imu_pkt_pkg::*;
#(
    parameter logic [7:0] SYNC0 = SYNC0_DEF,
    parameter logic [7:0] SYNC1 = SYNC1_DEF
) (
    input  logic        CLK_50,
    input  logic        RESET,
    input  logic        SAMPLE_STB,
    input  logic [15:0] ACCEL_XOUT,
    input  logic [15:0] ACCEL_YOUT,
    input  logic [15:0] ACCEL_ZOUT,
    input  logic [15:0] TEMP_OUT,
    input  logic [15:0] GYRO_XOUT,
    input  logic [15:0] GYRO_YOUT,
    input  logic [15:0] GYRO_ZOUT,
    input  logic [15:0] HM_XOUT,
    input  logic [15:0] HM_YOUT,
    input  logic [15:0] HM_ZOUT,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic        BUSY,
    output logic [7:0]  SEQ,
    output logic [15:0] DROP_CNT
);

    state_t         state_q,   state_d;
    logic [4:0]     bidx_q,    bidx_d;
    logic [7:0]     acc_q,     acc_d;
    logic [159:0]   snap_q,    snap_d;
    logic [7:0]     pkt_seq_q, pkt_seq_d;
    logic [7:0]     seq_q,     seq_d;
    logic [15:0]    drop_q,    drop_d;
    logic [7:0]     tx_data_q, tx_data_d;

    logic           xfer_s;
    logic [7:0]     cur_byte_s;
    logic [159:0]   inputs_s;

    // Byte mux: packet byte at position idx given snapshot, sequence and checksum.
    function automatic logic [7:0] pkt_byte(input logic [4:0]   idx,
                                            input logic [159:0] snap,
                                            input logic [7:0]   seq,
                                            input logic [7:0]   acc);
        logic [7:0] b;
        case (idx)
            5'd0:     b = SYNC0;
            5'd1:     b = SYNC1;
            IDX_SEQ:  b = seq;
            IDX_CSUM: b = acc;
            default:  b = snap_byte(snap, idx);
        endcase
        return b;
    endfunction

    assign inputs_s = {ACCEL_XOUT, ACCEL_YOUT, ACCEL_ZOUT, TEMP_OUT,
                       GYRO_XOUT,  GYRO_YOUT,  GYRO_ZOUT,
                       HM_XOUT,    HM_YOUT,    HM_ZOUT};

    // Next-state logic: packet sequencing, checksum accumulation, drop counting.
    always_comb begin
        state_d    = state_q;
        bidx_d     = bidx_q;
        acc_d      = acc_q;
        snap_d     = snap_q;
        pkt_seq_d  = pkt_seq_q;
        seq_d      = seq_q;
        drop_d     = drop_q;
        xfer_s     = (state_q == SEND) && TX_READY;
        cur_byte_s = pkt_byte(bidx_q, snap_q, pkt_seq_q, acc_q);

        case (state_q)
            IDLE: begin
                if (SAMPLE_STB) begin
                    snap_d    = inputs_s;
                    pkt_seq_d = seq_q;
                    acc_d     = 8'h00;
                    bidx_d    = 5'd0;
                    state_d   = SEND;
                end else begin
                    state_d   = IDLE;
                end
            end
            SEND: begin
                if (xfer_s && (bidx_q == IDX_CSUM)) begin
                    seq_d = seq_q + 8'd1;
                    if (SAMPLE_STB) begin
                        // Back-to-back: new packet starts without an idle gap.
                        snap_d    = inputs_s;
                        pkt_seq_d = seq_q + 8'd1;
                        acc_d     = 8'h00;
                        bidx_d    = 5'd0;
                    end else begin
                        bidx_d    = 5'd0;
                        state_d   = IDLE;
                    end
                end else begin
                    if (xfer_s) begin
                        // Sync bytes (0,1) are not part of the checksum.
                        if (bidx_q >= IDX_SEQ) begin
                            acc_d = acc_q + cur_byte_s;
                        end else begin
                            acc_d = acc_q;
                        end
                        bidx_d = bidx_q + 5'd1;
                    end else begin
                        bidx_d = bidx_q;
                    end
                    if (SAMPLE_STB) begin
                        drop_d = (drop_q == 16'hFFFF) ? drop_q : (drop_q + 16'd1);
                    end else begin
                        drop_d = drop_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                bidx_d  = 5'd0;
            end
        endcase

        // Output byte is registered, so precompute it from the next state;
        // this also makes the checksum byte include byte 22.
        if (state_d == SEND) begin
            tx_data_d = pkt_byte(bidx_d, snap_d, pkt_seq_d, acc_d);
        end else begin
            tx_data_d = 8'h00;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            state_q   <= IDLE;
            bidx_q    <= 5'd0;
            acc_q     <= 8'h00;
            snap_q    <= 160'd0;
            pkt_seq_q <= 8'h00;
            seq_q     <= 8'h00;
            drop_q    <= 16'h0000;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            bidx_q    <= bidx_d;
            acc_q     <= acc_d;
            snap_q    <= snap_d;
            pkt_seq_q <= pkt_seq_d;
            seq_q     <= seq_d;
            drop_q    <= drop_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign TX_VALID = (state_q == SEND);
    assign BUSY     = (state_q == SEND);
    assign TX_DATA  = tx_data_q;
    assign SEQ      = seq_q;
    assign DROP_CNT = drop_q;

endmodule

// File: tb/tb_imu_sample_packer.sv
// Scoreboard bench for imu_sample_packer: stimulus pushes expected bytes,
// a negedge monitor pops and compares every transferred byte.
module tb_imu_sample_packer;

    typedef logic [9:0][15:0] words_t;

    logic        CLK_50 = 1'b0;
    logic        RESET = 1'b1;
    logic        SAMPLE_STB = 1'b0;
    logic [15:0] ACCEL_XOUT = 16'h0, ACCEL_YOUT = 16'h0, ACCEL_ZOUT = 16'h0;
    logic [15:0] TEMP_OUT = 16'h0;
    logic [15:0] GYRO_XOUT = 16'h0, GYRO_YOUT = 16'h0, GYRO_ZOUT = 16'h0;
    logic [15:0] HM_XOUT = 16'h0, HM_YOUT = 16'h0, HM_ZOUT = 16'h0;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY = 1'b0;
    logic        BUSY;
    logic [7:0]  SEQ;
    logic [15:0] DROP_CNT;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_seq = 8'h00;
    logic        stall_prev = 1'b0;
    logic [7:0]  held_data = 8'h00;

    imu_sample_packer dut (
        .CLK_50(CLK_50), .RESET(RESET), .SAMPLE_STB(SAMPLE_STB),
        .ACCEL_XOUT(ACCEL_XOUT), .ACCEL_YOUT(ACCEL_YOUT), .ACCEL_ZOUT(ACCEL_ZOUT),
        .TEMP_OUT(TEMP_OUT),
        .GYRO_XOUT(GYRO_XOUT), .GYRO_YOUT(GYRO_YOUT), .GYRO_ZOUT(GYRO_ZOUT),
        .HM_XOUT(HM_XOUT), .HM_YOUT(HM_YOUT), .HM_ZOUT(HM_ZOUT),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .BUSY(BUSY), .SEQ(SEQ), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK_50 = ~CLK_50;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference packet builder: sync, seq, data high byte first, mod-256 sum of bytes 2..22.
    task automatic push_pkt(input words_t w, input logic [7:0] s);
        logic [7:0] sum;
        sum = s;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(s);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(w[i][15:8]);
            exp_q.push_back(w[i][7:0]);
            sum = sum + w[i][15:8] + w[i][7:0];
        end
        exp_q.push_back(sum);
    endtask

    task automatic set_words(input words_t w);
        ACCEL_XOUT = w[0]; ACCEL_YOUT = w[1]; ACCEL_ZOUT = w[2]; TEMP_OUT = w[3];
        GYRO_XOUT  = w[4]; GYRO_YOUT  = w[5]; GYRO_ZOUT  = w[6];
        HM_XOUT    = w[7]; HM_YOUT    = w[8]; HM_ZOUT    = w[9];
    endtask

    task automatic tick();
        @(posedge CLK_50);
        #1;
    endtask

    task automatic rand_words(output words_t w);
        for (int i = 0; i < 10; i++) w[i] = 16'($urandom);
    endtask

    // Pulse SAMPLE_STB from idle; optionally queue the model packet.
    task automatic start_pkt(input words_t w, input bit use_model);
        tick();
        set_words(w);
        SAMPLE_STB = 1'b1;
        if (use_model) push_pkt(w, exp_seq);
        exp_seq = exp_seq + 8'd1;
        tick();
        SAMPLE_STB = 1'b0;
        chk("latency_valid", {31'd0, TX_VALID}, 32'd1);
        chk("first_byte", {24'd0, TX_DATA}, {24'd0, 8'hA5});
    endtask

    // Drive TX_READY until the packet ends. mode 1 toggles ready starting high.
    // stb_at pulses a strobe at that cycle; rst_at asserts RESET at that cycle.
    task automatic run_pkt(input int mode, input int stb_at, input words_t w2,
                           input int rst_at, output int cyc);
        bit b2b;
        cyc = 0;
        while (TX_VALID === 1'b1 && cyc < 2000) begin
            TX_READY = (mode == 1) ? ((cyc % 2) == 0) : 1'b1;
            b2b = 1'b0;
            if (cyc == stb_at) begin
                set_words(w2);
                SAMPLE_STB = 1'b1;
                if (stb_at == 23 && mode == 0) begin
                    b2b = 1'b1;
                    push_pkt(w2, exp_seq);
                    exp_seq = exp_seq + 8'd1;
                end
            end
            if (cyc == rst_at) begin
                TX_READY = 1'b0;
                RESET = 1'b1;
            end
            tick();
            SAMPLE_STB = 1'b0;
            if (cyc == rst_at) begin
                RESET = 1'b0;
                exp_q.delete();
                exp_seq = 8'h00;
                chk("rst_valid", {31'd0, TX_VALID}, 32'd0);
                chk("rst_seq", {24'd0, SEQ}, 32'd0);
                chk("rst_drop", {16'd0, DROP_CNT}, 32'd0);
            end
            if (b2b) begin
                chk("b2b_valid", {31'd0, TX_VALID}, 32'd1);
                chk("b2b_sync", {24'd0, TX_DATA}, {24'd0, 8'hA5});
            end
            cyc++;
        end
        TX_READY = 1'b0;
        if (cyc >= 2000) chk("timeout", 32'd1, 32'd0);
    endtask

    // Monitor: compare every transferred byte, check stall stability and idle zero.
    always @(negedge CLK_50) begin
        if (!RESET) begin
            if (TX_VALID) begin
                if (stall_prev) chk("stall_stable", {24'd0, TX_DATA}, {24'd0, held_data});
                if (TX_READY) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", {24'd0, TX_DATA}, 32'hFFFF_FFFF);
                    end else begin
                        chk("tx_byte", {24'd0, TX_DATA}, {24'd0, exp_q.pop_front()});
                    end
                end
                stall_prev = !TX_READY;
                held_data  = TX_DATA;
            end else begin
                stall_prev = 1'b0;
                if (TX_DATA !== 8'h00) chk("idle_data", {24'd0, TX_DATA}, 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        words_t w, wr, ones;
        int     cyc;

        ones = '1;
        repeat (3) tick();
        RESET = 1'b0;
        tick();
        chk("reset_valid", {31'd0, TX_VALID}, 32'd0);
        chk("reset_busy", {31'd0, BUSY}, 32'd0);
        chk("reset_data", {24'd0, TX_DATA}, 32'd0);
        chk("reset_seq", {24'd0, SEQ}, 32'd0);
        chk("reset_drop", {16'd0, DROP_CNT}, 32'd0);

        // Hand-computed packet: ACCEL_X=1234 -> CSUM 00+12+34 = 46.
        w = '0;
        w[0] = 16'h1234;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(8'h00);
        exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        for (int i = 0; i < 18; i++) exp_q.push_back(8'h00);
        exp_q.push_back(8'h46);
        start_pkt(w, 1'b0);
        run_pkt(0, -1, w, -1, cyc);
        chk("pkt_cycles", cyc, 32'd24);
        chk("seq_after_1", {24'd0, SEQ}, 32'd1);

        // Toggling ready: same bytes over 47 cycles.
        start_pkt(w, 1'b1);
        run_pkt(1, -1, w, -1, cyc);
        chk("toggle_cycles", cyc, 32'd47);

        // Inputs change right after capture; packet must carry captured values.
        rand_words(w);
        start_pkt(w, 1'b1);
        rand_words(wr);
        set_words(wr);
        run_pkt(0, -1, w, -1, cyc);

        // Strobe at byte 10 is dropped, packet unchanged.
        rand_words(w);
        rand_words(wr);
        start_pkt(w, 1'b1);
        run_pkt(0, 10, wr, -1, cyc);
        chk("drop_cnt", {16'd0, DROP_CNT}, 32'd1);

        // Strobe coincident with byte-23 transfer: back-to-back packet.
        rand_words(w);
        rand_words(wr);
        start_pkt(w, 1'b1);
        run_pkt(0, 23, wr, -1, cyc);
        chk("b2b_cycles", cyc, 32'd48);
        chk("drop_after_b2b", {16'd0, DROP_CNT}, 32'd1);

        // Reset at byte 12 aborts the packet and clears counters.
        rand_words(w);
        start_pkt(w, 1'b1);
        run_pkt(0, -1, w, 12, cyc);
        chk("rst_cycles", cyc, 32'd13);

        // 257 all-FFFF packets: SEQ byte 00..FF then 00; CSUM = SEQ + EC.
        for (int p = 0; p < 257; p++) begin
            start_pkt(ones, 1'b1);
            if (p == 0) chk("fresh_after_reset", {24'd0, TX_DATA}, {24'd0, 8'hA5});
            run_pkt(0, -1, ones, -1, cyc);
            if (p == 255) chk("seq_wrap", {24'd0, SEQ}, 32'd0);
        end
        chk("seq_after_257", {24'd0, SEQ}, 32'd1);

        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
